// File: rtl/sdhci_cmd_pkg.sv
// Shared types and frame constants for the SD command-line write path.
package sdhci_cmd_pkg;

   localparam int CMD_FRAME_BITS = 48;
   localparam int CMD_CRC_FIRST  = 40;
   localparam int CMD_CRC_BITS   = 7;
   localparam int INIT_CLOCKS    = 74;

   typedef logic [5:0] cmd_index_t;

   typedef enum logic [1:0] {
      IDLE,
      INIT,
      SEND,
      GAP
   } cmd_wr_state_e;

endpackage

// File: rtl/crc7_write.sv
// Serial CRC7 (x^7 + x^3 + 1): accumulates data bits, then shifts the remainder out MSb first.
module crc7_write (
   input  logic clk,
   input  logic rst_n,
   input  logic dat_ser,
   input  logic shift_out,
   output logic crc_ser
);

   logic [6:0] crc_q;
   logic       fb;

   assign fb      = dat_ser ^ crc_q[6];
   assign crc_ser = crc_q[6];

   // Shift-out back-fills zeros, leaving the register clear for the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc_q <= '0;
      end else if (shift_out) begin
         crc_q <= {crc_q[5:0], 1'b0};
      end else begin
         crc_q <= {crc_q[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
      end
   end

endmodule

// File: rtl/sd_cmd_write_ctrl.sv
// SD CMD-line transmitter: serializes a 48-bit command frame with CRC7 and enforces an Ncc gap.
// Optional power-up clock phase enabled by defining SDHCI_CMD_INIT_CLOCKS_EN.
module sd_cmd_write_ctrl
   import sdhci_cmd_pkg::*;
#(
   parameter int NCC_CYCLES = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [5:0]  cmd_index_i,
   input  logic [31:0] cmd_arg_i,
   output logic        cmd_o,
   output logic        cmd_oe_o,
   output logic        busy_o,
   output logic        done_o
);

   localparam logic [5:0] CNT_CRC_FIRST = 6'(CMD_CRC_FIRST);
   localparam logic [5:0] CNT_CRC_LAST  = 6'(CMD_CRC_FIRST + CMD_CRC_BITS - 1);
   localparam logic [5:0] CNT_LAST      = 6'(CMD_FRAME_BITS - 1);
   localparam logic [7:0] GAP_LAST      = 8'(NCC_CYCLES - 1);

`ifdef SDHCI_CMD_INIT_CLOCKS_EN
   localparam logic [6:0]    INIT_LAST = 7'(INIT_CLOCKS - 1);
   localparam cmd_wr_state_e RST_STATE = INIT;
   localparam logic          RST_OE    = 1'b1;
   logic [6:0] init_cnt;
`else
   localparam cmd_wr_state_e RST_STATE = IDLE;
   localparam logic          RST_OE    = 1'b0;
`endif

   cmd_wr_state_e state;
   logic [5:0]    cnt;
   logic [7:0]    gap_cnt;
   logic [37:0]   shreg;
   cmd_index_t    idx_in;
   logic          bit_next;
   logic          crc_ser;
   logic          dat_ser;
   logic          shift_out;
   logic          in_send;

   assign idx_in      = cmd_index_i;
   assign in_send     = (state == SEND);
   assign cmd_ready_o = (state == IDLE);
   assign busy_o      = (state != IDLE);

   always_comb begin
      bit_next = 1'b1;
      if (cnt == 6'd0) begin
         bit_next = 1'b0;
      end else if (cnt == 6'd1) begin
         bit_next = 1'b1;
      end else if (cnt < CNT_CRC_FIRST) begin
         bit_next = shreg[37];
      end else if (cnt <= CNT_CRC_LAST) begin
         bit_next = crc_ser;
      end
   end

   assign dat_ser   = in_send && (cnt < CNT_CRC_FIRST) && bit_next;
   assign shift_out = in_send && (cnt >= CNT_CRC_FIRST) && (cnt <= CNT_CRC_LAST);

   crc7_write u_crc7 (
      .clk       (clk_i),
      .rst_n     (rst_ni),
      .dat_ser   (dat_ser),
      .shift_out (shift_out),
      .crc_ser   (crc_ser)
   );

   // Payload register: index then argument, consumed MSb first during frame bits 2..39.
   always_ff @(posedge clk_i) begin
      if ((state == IDLE) && cmd_valid_i) begin
         shreg <= {idx_in, cmd_arg_i};
      end else if (in_send && (cnt >= 6'd2) && (cnt < CNT_CRC_FIRST)) begin
         shreg <= {shreg[36:0], 1'b0};
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state    <= RST_STATE;
         cnt      <= '0;
         gap_cnt  <= '0;
`ifdef SDHCI_CMD_INIT_CLOCKS_EN
         init_cnt <= '0;
`endif
         cmd_o    <= 1'b1;
         cmd_oe_o <= RST_OE;
         done_o   <= 1'b0;
      end else begin
         cmd_o    <= 1'b1;
         cmd_oe_o <= 1'b0;
         done_o   <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid_i) begin
                  state <= SEND;
                  cnt   <= '0;
               end
            end
`ifdef SDHCI_CMD_INIT_CLOCKS_EN
            INIT: begin
               // Keep driving through the last INIT cycle, release as IDLE begins.
               cmd_oe_o <= (init_cnt != INIT_LAST);
               if (init_cnt == INIT_LAST) begin
                  state    <= IDLE;
                  init_cnt <= '0;
               end else begin
                  init_cnt <= init_cnt + 7'd1;
               end
            end
`endif
            SEND: begin
               cmd_o    <= bit_next;
               cmd_oe_o <= 1'b1;
               if (cnt == CNT_LAST) begin
                  state   <= GAP;
                  cnt     <= '0;
                  gap_cnt <= '0;
               end else begin
                  cnt <= cnt + 6'd1;
               end
            end
            GAP: begin
               done_o <= (gap_cnt == 8'd0);
               if (gap_cnt == GAP_LAST) begin
                  state   <= IDLE;
                  gap_cnt <= '0;
               end else begin
                  gap_cnt <= gap_cnt + 8'd1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sd_cmd_write_ctrl.sv
// Directed bench for sd_cmd_write_ctrl: table of known SD frames plus back-to-back and mid-frame reset sequences.
module tb_sd_cmd_write_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0;
   logic [5:0]  idx = '0;
   logic [31:0] arg = '0;
   logic        ready, cmd, oe, busy, done;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [5:0]  idx;
      logic [31:0] arg;
      logic [47:0] frame;
      string       name;
   } vec_t;

   vec_t vecs[5];

   sd_cmd_write_ctrl #(.NCC_CYCLES(8)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .cmd_valid_i (valid),
      .cmd_ready_o (ready),
      .cmd_index_i (idx),
      .cmd_arg_i   (arg),
      .cmd_o       (cmd),
      .cmd_oe_o    (oe),
      .busy_o      (busy),
      .done_o      (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      for (int i = 0; i < 300; i++) begin
         if (ready === 1'b1) return;
         @(negedge clk);
      end
      chk("ready_timeout", {63'b0, ready}, 64'd1);
   endtask

   // Present a command, then sample cycles T+1..T+51 at the falling edge.
   task automatic send(input logic [5:0] i_idx, input logic [31:0] i_arg,
                       output logic [47:0] got, output int oe_err, output int done_err);
      got = '0; oe_err = 0; done_err = 0;
      @(negedge clk);
      idx = i_idx; arg = i_arg; valid = 1'b1;
      wait_ready();
      @(posedge clk);
      for (int n = 1; n <= 51; n++) begin
         @(negedge clk);
         if (n == 1) begin
            valid = 1'b0;
            if (oe !== 1'b0 || cmd !== 1'b1) oe_err++;
         end else if (n <= 49) begin
            got = {got[46:0], cmd};
            if (oe !== 1'b1 || busy !== 1'b1) oe_err++;
            if (done !== 1'b0) done_err++;
         end else if (n == 50) begin
            if (oe !== 1'b0 || cmd !== 1'b1) oe_err++;
            if (done !== 1'b1) done_err++;
         end else begin
            if (done !== 1'b0) done_err++;
         end
      end
   endtask

   initial begin
      logic [47:0] got, got2;
      int          oe_err, done_err, idle_cnt, low_cnt;
      logic        r56, r57;
      logic [1:0]  s59;

      vecs[0] = '{6'd0,  32'h0000_0000, 48'h4000_0000_0095, "cmd0"};
      vecs[1] = '{6'd8,  32'h0000_01AA, 48'h4800_0001_AA87, "cmd8"};
      vecs[2] = '{6'd55, 32'h0000_0000, 48'h7700_0000_0065, "cmd55"};
      vecs[3] = '{6'd17, 32'h0000_0000, 48'h5100_0000_0055, "cmd17"};
      vecs[4] = '{6'd41, 32'h4000_0000, 48'h6940_0000_0077, "acmd41"};

      repeat (3) @(negedge clk);
      chk("rst_cmd", {63'b0, cmd}, 64'd1);
      chk("rst_done", {63'b0, done}, 64'd0);
`ifdef SDHCI_CMD_INIT_CLOCKS_EN
      chk("rst_ready_init", {63'b0, ready}, 64'd0);
      chk("rst_busy_init", {63'b0, busy}, 64'd1);
      rst_n = 1'b1;
      low_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ready === 1'b1) break;
         if (valid !== 1'b1) valid = 1'b1;
         if (oe === 1'b1 && cmd === 1'b1) low_cnt++;
      end
      valid = 1'b0;
      chk("init_cycles", 64'(low_cnt), 64'd73);
      chk("init_ready", {63'b0, ready}, 64'd1);
`else
      chk("rst_oe", {63'b0, oe}, 64'd0);
      chk("rst_ready", {63'b0, ready}, 64'd1);
      chk("rst_busy", {63'b0, busy}, 64'd0);
      rst_n = 1'b1;
`endif

      for (int v = 0; v < 5; v++) begin
         send(vecs[v].idx, vecs[v].arg, got, oe_err, done_err);
         chk({vecs[v].name, "_frame"}, 64'(got), 64'(vecs[v].frame));
         chk({vecs[v].name, "_oe"}, 64'(oe_err), 64'd0);
         chk({vecs[v].name, "_done"}, 64'(done_err), 64'd0);
      end

      // Back-to-back CMD17 with valid held across the gap.
      got = '0; got2 = '0; idle_cnt = 0; r56 = 1'b0; r57 = 1'b0; s59 = '0;
      @(negedge clk);
      wait_ready();
      idx = 6'd17; arg = '0; valid = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 106; n++) begin
         @(negedge clk);
         if (n >= 2 && n <= 49) got = {got[46:0], cmd};
         if (n >= 50 && n <= 58 && cmd === 1'b1 && oe === 1'b0) idle_cnt++;
         if (n == 56) r56 = ready;
         if (n == 57) r57 = ready;
         if (n == 58) valid = 1'b0;
         if (n == 59) s59 = {cmd, oe};
         if (n >= 59) got2 = {got2[46:0], cmd};
      end
      chk("b2b_frame1", 64'(got), 64'h5100_0000_0055);
      chk("b2b_ready56", {63'b0, r56}, 64'd0);
      chk("b2b_ready57", {63'b0, r57}, 64'd1);
      chk("b2b_idle", 64'(idle_cnt), 64'd9);
      chk("b2b_start59", {62'b0, s59}, 64'd1);
      chk("b2b_frame2", 64'(got2), 64'h5100_0000_0055);

      // Reset while cnt=20, then confirm the CRC restarts clean.
      @(negedge clk);
      wait_ready();
      idx = 6'd0; arg = '0; valid = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 21; n++) begin
         @(negedge clk);
         if (n == 1) begin
            idx = 6'd55; arg = 32'hFFFF_FFFF; valid = 1'b0;
         end
      end
      #1 rst_n = 1'b0;
      #1;
      chk("mid_rst_cmd", {63'b0, cmd}, 64'd1);
      chk("mid_rst_oe", {63'b0, oe}, 64'd0);
      chk("mid_rst_done", {63'b0, done}, 64'd0);
`ifndef SDHCI_CMD_INIT_CLOCKS_EN
      chk("mid_rst_ready", {63'b0, ready}, 64'd1);
      chk("mid_rst_busy", {63'b0, busy}, 64'd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      send(6'd0, 32'h0, got, oe_err, done_err);
      chk("post_rst_crc", 64'(got[7:0]), 64'h95);
      chk("post_rst_frame", 64'(got), 64'h4000_0000_0095);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
